// File: rtl/sc_pkg.sv
// ============================================================================
// Module   : sc_pkg
// Brief    : Shared types and constants for the stochastic multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sc_state_e;

    localparam int LFSR_W         = 31;
    localparam int LFSR_TAP_HI    = 30;
    localparam int LFSR_TAP_LO    = 27;
    localparam int OP_W           = 4;
    localparam int DEF_EPOCH_LOG2 = 8;

    // x^31 + x^28 + 1, shifting toward the MSB
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_mult_scheduler_if.sv
// ============================================================================
// Module   : sc_mult_scheduler_if
// Brief    : Request/result bundle between requesters, consumer and scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sc_mult_scheduler_if
    import sc_pkg::*;
#(
    parameter int EPOCH_LOG2 = DEF_EPOCH_LOG2,
    parameter int CW         = EPOCH_LOG2 + 1
);
    logic [1:0]        req_valid;
    logic [2*OP_W-1:0] req_a;
    logic [2*OP_W-1:0] req_b;
    logic [1:0]        req_ready;
    logic              res_valid;
    logic              res_ready;
    logic              res_id;
    logic [CW-1:0]     res_count;
    logic              busy;
    logic              abort;

    modport master (
        output req_valid, req_a, req_b, res_ready, abort,
        input  req_ready, res_valid, res_id, res_count, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready, abort,
        output req_ready, res_valid, res_id, res_count, busy
    );

endinterface

`default_nettype wire

// File: rtl/sc_lfsr31.sv
// ============================================================================
// Module   : sc_lfsr31
// Brief    : Free-running 31-bit Fibonacci LFSR, seeded with 1 on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sc_lfsr31
    import sc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // rst_n is active-high and asynchronous in this codebase
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= LFSR_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/sc_mult_scheduler.sv
// ============================================================================
// Module   : sc_mult_scheduler
// Brief    : Round-robin scheduler sharing one stochastic multiplier between
//            two requesters; returns the product ones-count per epoch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sc_mult_scheduler
    import sc_pkg::*;
#(
    parameter int EPOCH_LOG2 = DEF_EPOCH_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    sc_mult_scheduler_if.slave bus
);

    localparam int CW = EPOCH_LOG2 + 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [LFSR_W-1:0]     lfsr;
    logic                  unused_lfsr_hi;

    logic [1:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  id_q, id_d;
    logic [OP_W-1:0]       a_q, a_d;
    logic [OP_W-1:0]       b_q, b_d;
    logic [EPOCH_LOG2-1:0] epoch_q, epoch_d;
    logic [CW-1:0]         ones_q, ones_d;

    logic                  any_req;
    logic                  grant_idx;
    logic [1:0]            grant;
    logic                  prod;

    sc_lfsr31 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:2*OP_W];

    always_comb begin
        any_req   = |bus.req_valid;
        grant_idx = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
        grant     = 2'b00;
        // no handshake may complete while reset is asserted
        if ((state_q == S_IDLE) && any_req && !rst_n) begin
            grant[grant_idx] = 1'b1;
        end
        prod = (lfsr[OP_W-1:0] < a_q) && (lfsr[2*OP_W-1:OP_W] < b_q);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        epoch_d = epoch_q;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_LOAD;
                    id_d    = grant_idx;
                    a_d     = grant_idx ? bus.req_a[2*OP_W-1:OP_W] : bus.req_a[OP_W-1:0];
                    b_d     = grant_idx ? bus.req_b[2*OP_W-1:OP_W] : bus.req_b[OP_W-1:0];
                    ptr_d   = ~grant_idx;
                end
            end
            S_LOAD: begin
                epoch_d = '0;
                ones_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                epoch_d = epoch_q + 1'b1;
                ones_d  = ones_q + {{(CW-1){1'b0}}, prod};
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (&epoch_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            epoch_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            epoch_q <= epoch_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_id    = id_q;
    assign bus.res_count = ones_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/sc_mult_scheduler.md
# sc_mult_scheduler

Controller that shares one unipolar stochastic multiplier between two requesters. It arbitrates operand requests round-robin, runs one fixed-length stochastic epoch per accepted job, and returns the ones-count with a valid/ready handshake. The multiplier is built from a free-running LFSR, two comparators, an AND gate and an up-counter. The block sits between host-side request logic and result consumers in the stochastic-computing test design.

## Interface
Parameters:
- EPOCH_LOG2, default 8: epoch length is 2^EPOCH_LOG2 cycles.
- CW, default EPOCH_LOG2+1: result count width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high (rst_n=1 resets).
- req_valid  in  2  request valid, one bit per requester.
- req_a  in  8  operand A; requester i on [4i+3:4i].
- req_b  in  8  operand B; same packing as req_a.
- req_ready  out  2  grant, one-hot, combinational; handshake is req_valid[i]&req_ready[i].
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  1  requester index of current result.
- res_count  out  CW  ones-count of product stream, 0..2^EPOCH_LOG2.
- busy  out  1  high whenever state != IDLE.
- abort  in  1  synchronous; cancels a running epoch.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if any req_valid, assert req_ready for exactly one requester; go to LOAD. Grant choice: the requester at the round-robin pointer wins if valid, else the other. After a grant the pointer moves to the non-granted requester. Pointer resets to 0. req_ready is 0 in all non-IDLE states.
- LOAD (1 cycle): latch the granted requester's a, b and id; clear epoch counter and ones counter.
- RUN (2^EPOCH_LOG2 cycles):
  - sa = (lfsr[3:0] < a); sb = (lfsr[7:4] < b); p = sa & sb.
  - Ones counter increments when p=1.
  - Epoch counter increments every cycle; leave RUN after the cycle in which it equals 2^EPOCH_LOG2-1.
- DONE: res_valid=1; res_count holds the final count; res_id holds the latched id. Return to IDLE on res_valid&res_ready. A new grant is possible in the following IDLE cycle.
- LFSR: 31 bits, x^31+x^28+1. Each cycle: lfsr <= {lfsr[29:0], lfsr[30]^lfsr[27]}. Reset value 31'd1. Free-running in all states; never reseeded except by reset.
- abort:
  - In RUN: go to IDLE next cycle, no result issued, the job is dropped; the round-robin pointer keeps its post-grant value.
  - In IDLE, LOAD and DONE: ignored.
- Arithmetic: a=0 or b=0 gives count exactly 0. The ones counter cannot exceed 2^EPOCH_LOG2, so no overflow handling is needed.
- Reset mid-operation: all state clears immediately and any in-flight job is lost.

## Timing
- Reset values: req_ready=0, res_valid=0, res_id=0, res_count=0, busy=0, state=IDLE, pointer=0, lfsr=1.
- Handshake in cycle t puts LOAD at t+1, RUN over t+2..t+1+2^E, and DONE with res_valid=1 at t+2+2^E. Total latency is 2^E+2 cycles.
- busy rises in cycle t+1.
- res_valid, res_id and res_count are registered and stay stable while res_valid=1 and res_ready=0.
- If res_ready is already high when DONE is entered, DONE lasts 1 cycle.
- Requests arriving while busy are held off (req_ready=0). Requesters must keep req_valid and their operands stable until granted.

## Structure
- Package sc_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - the LFSR width (31) and tap indices (30, 27);
  - the operand width (4);
  - the default EPOCH_LOG2.
- One sub-module: sc_lfsr31 (clk, rst_n, 31-bit state output, free-running).
- Arbiter, FSM, comparators and counters live in sc_mult_scheduler.

## Test plan
- Reset check: assert rst_n for 3 cycles -> all outputs 0. Release rst_n -> lfsr model matches from value 1.
- Single job: req 0 with a=0, b=9 -> res_valid at t+258, res_count=0, res_id=0. Then a=8, b=8 -> res_count equals the reference LFSR model exactly (≈64).
- Contention: both req_valid high continuously with different operands -> grants alternate 0,1,0,1, with res_id matching each grant and each count matching the model.
- Backpressure: hold res_ready=0 for 20 cycles in DONE -> res_valid, res_count and res_id stay stable, no grant occurs, busy=1. Raise res_ready -> IDLE next cycle.
- Abort: pulse abort 50 cycles into RUN -> IDLE next cycle, no res_valid, busy=0. The next grant goes to the other requester if it is valid.
- Reset mid-RUN: assert rst_n 100 cycles into RUN -> immediate return to reset values, no result issued. A fresh request then completes normally.
